serial_buffer: RTL

SERIAL_BUFFER -- requirements
Module: serial_buffer

---
 rtl/serial_buffer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/serial_buffer.sv
// CPU-facing byte buffer between a simple register bus and a serial_port.
// RX and TX each use a circular FIFO with an extra wrap bit on the pointers.
module serial_buffer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bus_addr,
    input  logic       bus_read,
    input  logic       bus_write,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       irq,
    input  logic       sp_int_req,
    output logic       sp_int_ack,
    input  logic [7:0] sp_data_out,
    output logic       sp_write_enable,
    input  logic       sp_write_busy,
    output logic [7:0] sp_data_in
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_WAIT} rx_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_PULSE, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_e;

    logic [7:0]    rx_mem_q [DEPTH];
    logic [7:0]    tx_mem_q [DEPTH];
    logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic          rx_full, rx_empty, tx_full, tx_empty;
    logic          rx_push_req, rx_push, rx_pop;
    logic          tx_push_req, tx_push, tx_pop;
    logic [7:0]    rx_head, tx_head;

    logic          irq_en_q, irq_en_d;
    logic          rx_ovr_q, rx_ovr_d;
    logic          tx_ovr_q, tx_ovr_d;
    logic [7:0]    bus_rdata_q, bus_rdata_d;

    rx_state_e     rx_state_q;
    tx_state_e     tx_state_q;
    logic          sp_int_ack_q;
    logic          sp_write_enable_q;
    logic [7:0]    sp_data_in_q;
    logic          tx_wait_q;

    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[PW-1] != rx_rd_q[PW-1]) && (rx_wr_q[PW-2:0] == rx_rd_q[PW-2:0]);
    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[PW-1] != tx_rd_q[PW-1]) && (tx_wr_q[PW-2:0] == tx_rd_q[PW-2:0]);

    assign rx_head = rx_mem_q[rx_rd_q[PW-2:0]];
    assign tx_head = tx_mem_q[tx_rd_q[PW-2:0]];

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign rx_push_req = (rx_state_q == RX_IDLE) && sp_int_req;
    assign rx_pop      = bus_read && !bus_addr && !rx_empty;
    assign rx_push     = rx_push_req && (!rx_full || rx_pop);

    assign tx_push_req = bus_write && !bus_addr;
    assign tx_pop      = (tx_state_q == TX_IDLE) && !tx_empty && !sp_write_busy;
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);

    always_comb begin
        rx_wr_d = rx_wr_q + {{(PW-1){1'b0}}, rx_push};
        rx_rd_d = rx_rd_q + {{(PW-1){1'b0}}, rx_pop};
        tx_wr_d = tx_wr_q + {{(PW-1){1'b0}}, tx_push};
        tx_rd_d = tx_rd_q + {{(PW-1){1'b0}}, tx_pop};
    end

    // Reads see the pre-write state of every flag and FIFO.
    always_comb begin
        bus_rdata_d = bus_rdata_q;
        if (bus_read) begin
            if (bus_addr)
                bus_rdata_d = {3'b000, irq_en_q, tx_ovr_q, rx_ovr_q, !tx_full, !rx_empty};
            else if (!rx_empty)
                bus_rdata_d = rx_head;
            else
                bus_rdata_d = 8'h00;
        end
    end

    // Clears are applied first so a same-cycle set wins.
    always_comb begin
        irq_en_d = irq_en_q;
        rx_ovr_d = rx_ovr_q;
        tx_ovr_d = tx_ovr_q;
        if (bus_write && bus_addr) begin
            irq_en_d = bus_wdata[4];
            if (bus_wdata[2]) rx_ovr_d = 1'b0;
            if (bus_wdata[3]) tx_ovr_d = 1'b0;
        end
        if (rx_push_req && !rx_push) rx_ovr_d = 1'b1;
        if (tx_push_req && !tx_push) tx_ovr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem_q[rx_wr_q[PW-2:0]] <= sp_data_out;
        if (tx_push) tx_mem_q[tx_wr_q[PW-2:0]] <= bus_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
            irq_en_q    <= 1'b0;
            rx_ovr_q    <= 1'b0;
            tx_ovr_q    <= 1'b0;
            bus_rdata_q <= 8'h00;
        end else begin
            rx_wr_q     <= rx_wr_d;
            rx_rd_q     <= rx_rd_d;
            tx_wr_q     <= tx_wr_d;
            tx_rd_q     <= tx_rd_d;
            irq_en_q    <= irq_en_d;
            rx_ovr_q    <= rx_ovr_d;
            tx_ovr_q    <= tx_ovr_d;
            bus_rdata_q <= bus_rdata_d;
        end
    end

    // Receive handshake: capture on request, ack once, wait for request to drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q   <= RX_IDLE;
            sp_int_ack_q <= 1'b0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (sp_int_req) begin
                        rx_state_q   <= RX_ACK;
                        sp_int_ack_q <= 1'b1;
                    end
                end
                RX_ACK: begin
                    rx_state_q   <= RX_WAIT;
                    sp_int_ack_q <= 1'b0;
                end
                RX_WAIT: begin
                    if (!sp_int_req) rx_state_q <= RX_IDLE;
                end
                default: begin
                    rx_state_q   <= RX_IDLE;
                    sp_int_ack_q <= 1'b0;
                end
            endcase
        end
    end

    // Transmit: strobe one byte, give the port up to two cycles to raise busy,
    // then hold sp_data_in until busy drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q        <= TX_IDLE;
            sp_write_enable_q <= 1'b0;
            sp_data_in_q      <= 8'h00;
            tx_wait_q         <= 1'b0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_pop) begin
                        sp_data_in_q      <= tx_head;
                        sp_write_enable_q <= 1'b1;
                        tx_state_q        <= TX_PULSE;
                    end
                end
                TX_PULSE: begin
                    sp_write_enable_q <= 1'b0;
                    tx_wait_q         <= 1'b0;
                    tx_state_q        <= TX_WAIT_BUSY;
                end
                TX_WAIT_BUSY: begin
                    if (sp_write_busy || tx_wait_q)
                        tx_state_q <= TX_WAIT_DONE;
                    else
                        tx_wait_q <= 1'b1;
                end
                TX_WAIT_DONE: begin
                    if (!sp_write_busy) tx_state_q <= TX_IDLE;
                end
                default: begin
                    tx_state_q        <= TX_IDLE;
                    sp_write_enable_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus_rdata       = bus_rdata_q;
    assign irq             = irq_en_q && !rx_empty;
    assign sp_int_ack      = sp_int_ack_q;
    assign sp_write_enable = sp_write_enable_q;
    assign sp_data_in      = sp_data_in_q;

endmodule
